opr_3x3_ctrl: RTL

Sequencing controller for the 3x3 line-buffer window generator in the canny pipeline. It tracks column and row position of the accepted pixel stream (`din_vld`) across one frame. It asserts `win_vld` only in the cycles when the nine window registers hold a complete, spatially coherent 3x3 neighbourhood, and tags each window with its centre coordinate. It also frames the stream with line-end and frame-done pulses and reports protocol errors. It sits beside the window generator, sees the same `din_vld`, and drives downstream Sobel/NMS stages.

---
 rtl/opr_3x3_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/opr_3x3_ctrl.sv
// opr_3x3_ctrl: sequencing controller for the 3x3 line-buffer window generator.
// It tracks the (x,y) position of accepted pixels across one frame. It qualifies
// the cycles in which the nine window registers hold a coherent 3x3
// neighbourhood and tags each window with its centre coordinate. It also emits
// line-end and frame-done pulses and sticky protocol error flags.
//
// Optional feature macro: OPR_CTRL_GAP_CHK_EN
//   defined   : a 2-cycle din_vld history is kept. A window also needs din_vld in
//               both preceding cycles. A broken candidate sets err_gap.
//   undefined : there is no history. Windows depend only on x>=2, y>=2, and
//               err_gap is tied to 0.
//
// Stream semantics: din_vld is a pure qualifier with no ready/backpressure.
// A pixel is accepted in every cycle din_vld is high in ACTIVE, or in any cycle
// that also carries frame_start. win_vld is likewise a one-cycle qualifier with
// no handshake, so downstream must sample it every cycle.

module opr_3x3_ctrl #(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 768,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          din_vld,
  output logic          win_vld,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          line_end,
  output logic          frame_done,
  output logic          busy,
  output logic          err_stray,
  output logic          err_gap,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  state_t        state;
  state_t        state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic pix_adv;     // pixel accepted at the current (x,y) position
  logic at_x_last;
  logic at_y_last;
  logic last_pix;
  logic cand;        // accepted pixel completes a candidate window
  logic contig;      // din_vld was high in both preceding cycles
  logic idle_start;  // IDLE->ACTIVE transition, which clears sticky flags

  // A frame_start pixel becomes (0,0) of the new frame, so it never advances
  // the old position and never qualifies a window.
  assign pix_adv    = (state == S_ACTIVE) && din_vld && !frame_start;
  assign at_x_last  = (x == X_LAST);
  assign at_y_last  = (y == Y_LAST);
  assign last_pix   = pix_adv && at_x_last && at_y_last;
  assign cand       = pix_adv && (x >= X_TWO) && (y >= Y_TWO);
  assign idle_start = (state == S_IDLE) && frame_start;

`ifdef OPR_CTRL_GAP_CHK_EN
  // hist[0] holds din_vld from the previous cycle and hist[1] from the cycle before.
  logic [1:0] hist;

  // Shift din_vld history every clock, because the window registers shift every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 2'b00;
    else     hist <= {hist[0], din_vld};
  end

  assign contig = &hist;

  // Sticky gap error: a candidate window was broken by a din_vld hole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  err_gap <= 1'b0;
    else if (idle_start)      err_gap <= 1'b0;
    else if (cand && !contig) err_gap <= 1'b1;
  end
`else
  assign contig  = 1'b1;
  assign err_gap = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; frame_start restarts from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (frame_start) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (frame_start)   state_nxt = S_ACTIVE;
        else if (last_pix) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = frame_start ? S_ACTIVE : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs and the combinational line-end pulse.
  always_comb begin
    busy       = (state == S_ACTIVE);
    frame_done = (state == S_DONE);
    line_end   = pix_adv && at_x_last;
    state_dbg  = state;
  end

  // Column/row counters. After the last pixel they return to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (frame_start) begin
      x <= din_vld ? XW'(1) : '0;
      y <= '0;
    end else if (pix_adv) begin
      if (at_x_last) begin
        x <= '0;
        y <= at_y_last ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Window qualifier and centre tag, registered with the window registers' capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_vld <= 1'b0;
      win_x   <= '0;
      win_y   <= '0;
    end else begin
      win_vld <= cand && contig;
      if (cand && contig) begin
        win_x <= x - XW'(1);
        win_y <= y - YW'(1);
      end
    end
  end

  // Sticky stray-pixel error: din_vld seen while no frame is armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 err_stray <= 1'b0;
    else if (idle_start)                     err_stray <= 1'b0;
    else if ((state == S_IDLE) && din_vld)   err_stray <= 1'b1;
  end

endmodule
